// File: rtl/ctrl_alu_if.sv
// Issue-side packet, bypass network, resolved branch outputs and statistics
// counters of the control ALU, bundled for the issue (master) and ALU (slave) ends.
interface ctrl_alu_if #(
  parameter int ISSUE_WIDTH       = 4,
  parameter int SIZE_DATA         = 32,
  parameter int SIZE_PC           = 32,
  parameter int SIZE_PHYSICAL_LOG = 7,
  parameter int SIZE_IMM          = 26
);
  logic                                             valid_i;
  logic [7:0]                                       opcode_i;
  logic [1:0]                                       ctrl_type_i;
  logic [SIZE_PC-1:0]                               pc_i;
  logic [SIZE_IMM-1:0]                              immed_i;
  logic [SIZE_PC-1:0]                               pred_npc_i;
  logic                                             pred_dir_i;
  logic [SIZE_PHYSICAL_LOG-1:0]                     phy_src1_i;
  logic [SIZE_PHYSICAL_LOG-1:0]                     phy_src2_i;
  logic [SIZE_DATA-1:0]                             src1_data_i;
  logic [SIZE_DATA-1:0]                             src2_data_i;
  logic [ISSUE_WIDTH-1:0]                           byp_valid_i;
  logic [ISSUE_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]    byp_tag_i;
  logic [ISSUE_WIDTH-1:0][SIZE_DATA-1:0]            byp_data_i;
  logic [SIZE_DATA-1:0]                             result_o;
  logic [SIZE_PC-1:0]                               next_pc_o;
  logic                                             dir_o;
  logic                                             mispredict_o;
  logic                                             dest_valid_o;
  logic [31:0]                                      stat_pred_o;
  logic [31:0]                                      stat_corr_o;
  logic [31:0]                                      stat_recover_o;
  logic [31:0]                                      stat_cond_pred_o;
  logic [31:0]                                      stat_cond_corr_o;
  logic [31:0]                                      stat_ret_pred_o;
  logic [31:0]                                      stat_ret_corr_o;

  modport master (
    output valid_i, opcode_i, ctrl_type_i, pc_i, immed_i, pred_npc_i, pred_dir_i,
           phy_src1_i, phy_src2_i, src1_data_i, src2_data_i,
           byp_valid_i, byp_tag_i, byp_data_i,
    input  result_o, next_pc_o, dir_o, mispredict_o, dest_valid_o,
           stat_pred_o, stat_corr_o, stat_recover_o, stat_cond_pred_o,
           stat_cond_corr_o, stat_ret_pred_o, stat_ret_corr_o
  );

  modport slave (
    input  valid_i, opcode_i, ctrl_type_i, pc_i, immed_i, pred_npc_i, pred_dir_i,
           phy_src1_i, phy_src2_i, src1_data_i, src2_data_i,
           byp_valid_i, byp_tag_i, byp_data_i,
    output result_o, next_pc_o, dir_o, mispredict_o, dest_valid_o,
           stat_pred_o, stat_corr_o, stat_recover_o, stat_cond_pred_o,
           stat_cond_corr_o, stat_ret_pred_o, stat_ret_corr_o
  );
endinterface

// File: rtl/ctrl_alu.sv
// Control-pipe execution unit: bypass-resolved operands, branch/jump resolution,
// misprediction detection and clocked prediction statistics.
module ctrl_alu #(
    parameter int ISSUE_WIDTH       = 4,
    parameter int SIZE_DATA         = 32,
    parameter int SIZE_PC           = 32,
    parameter int SIZE_PHYSICAL_LOG = 7,
    parameter int SIZE_IMM          = 26
) (
    input logic        clk,
    input logic        reset,
    ctrl_alu_if.slave  bus
);

    localparam logic [7:0] OP_J    = 8'h01;
    localparam logic [7:0] OP_JAL  = 8'h02;
    localparam logic [7:0] OP_JR   = 8'h03;
    localparam logic [7:0] OP_JALR = 8'h04;
    localparam logic [7:0] OP_BEQ  = 8'h05;
    localparam logic [7:0] OP_BNE  = 8'h06;
    localparam logic [7:0] OP_BLEZ = 8'h07;
    localparam logic [7:0] OP_BGTZ = 8'h08;
    localparam logic [7:0] OP_BLTZ = 8'h09;
    localparam logic [7:0] OP_BGEZ = 8'h0A;

    localparam logic [1:0] CT_COND   = 2'd1;
    localparam logic [1:0] CT_RETURN = 2'd2;

    // Lowest-index matching bypass port wins, so scan from the top down.
    function automatic logic [SIZE_DATA-1:0] fwd(
        input logic [SIZE_PHYSICAL_LOG-1:0]                  tag,
        input logic [SIZE_DATA-1:0]                          rf,
        input logic [ISSUE_WIDTH-1:0]                        bv,
        input logic [ISSUE_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] bt,
        input logic [ISSUE_WIDTH-1:0][SIZE_DATA-1:0]         bd
    );
        logic [SIZE_DATA-1:0] res;
        res = rf;
        for (int k = ISSUE_WIDTH - 1; k >= 0; k--) begin
            if (bv[k] && (bt[k] == tag)) res = bd[k];
        end
        return res;
    endfunction

    function automatic logic [SIZE_PC-1:0] branch_off(input logic [15:0] imm);
        logic signed [SIZE_PC-1:0] ext;
        ext = {{(SIZE_PC-16){imm[15]}}, imm};
        return SIZE_PC'(ext <<< 3);
    endfunction

    logic signed [SIZE_DATA-1:0] a;
    logic signed [SIZE_DATA-1:0] b;
    logic [SIZE_PC-1:0]          seq;
    logic [SIZE_PC-1:0]          taken_pc;
    logic [SIZE_PC-1:0]          next_pc;
    logic [SIZE_DATA-1:0]        result;
    logic                        dir;
    logic                        dest_valid;
    logic                        defined;
    logic                        mispredict;

    always_comb begin
        a          = fwd(bus.phy_src1_i, bus.src1_data_i, bus.byp_valid_i, bus.byp_tag_i, bus.byp_data_i);
        b          = fwd(bus.phy_src2_i, bus.src2_data_i, bus.byp_valid_i, bus.byp_tag_i, bus.byp_data_i);
        seq        = bus.pc_i + SIZE_PC'(8);
        taken_pc   = seq + branch_off(bus.immed_i[15:0]);
        next_pc    = seq;
        result     = '0;
        dir        = 1'b0;
        dest_valid = 1'b0;
        defined    = 1'b1;
        unique case (bus.opcode_i)
            OP_J, OP_JAL: begin
                next_pc = {bus.pc_i[SIZE_PC-1 -: 4], bus.immed_i, 2'b00};
                dir     = 1'b1;
            end
            OP_JR, OP_JALR: begin
                next_pc = SIZE_PC'(a);
                dir     = 1'b1;
            end
            OP_BEQ:  dir = (a == b);
            OP_BNE:  dir = (a != b);
            OP_BLEZ: dir = (a <= 0);
            OP_BGTZ: dir = (a > 0);
            OP_BLTZ: dir = (a < 0);
            OP_BGEZ: dir = (a >= 0);
            default: defined = 1'b0;
        endcase
        if (bus.opcode_i == OP_JAL || bus.opcode_i == OP_JALR) begin
            result     = SIZE_DATA'(seq);
            dest_valid = 1'b1;
        end
        if (bus.opcode_i >= OP_BEQ && bus.opcode_i <= OP_BGEZ && dir) next_pc = taken_pc;
        mispredict = bus.valid_i && defined && (next_pc != bus.pred_npc_i);
    end

    assign bus.next_pc_o    = next_pc;
    assign bus.result_o     = result;
    assign bus.dir_o        = dir;
    assign bus.dest_valid_o = dest_valid;
    assign bus.mispredict_o = mispredict;

    // Predicted direction is carried for the front end only; resolution is target based.
    logic unused_pred_dir;
    assign unused_pred_dir = bus.pred_dir_i;

    logic [31:0] stat_pred, stat_corr, stat_recover;
    logic [31:0] stat_cond_pred, stat_cond_corr, stat_ret_pred, stat_ret_corr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pred      <= '0;
            stat_corr      <= '0;
            stat_recover   <= '0;
            stat_cond_pred <= '0;
            stat_cond_corr <= '0;
            stat_ret_pred  <= '0;
            stat_ret_corr  <= '0;
        end else if (bus.valid_i) begin
            stat_pred <= stat_pred + 32'd1;
            if (mispredict) stat_recover <= stat_recover + 32'd1;
            else            stat_corr    <= stat_corr + 32'd1;
            if (bus.ctrl_type_i == CT_COND) begin
                stat_cond_pred <= stat_cond_pred + 32'd1;
                if (!mispredict) stat_cond_corr <= stat_cond_corr + 32'd1;
            end
            if (bus.ctrl_type_i == CT_RETURN) begin
                stat_ret_pred <= stat_ret_pred + 32'd1;
                if (!mispredict) stat_ret_corr <= stat_ret_corr + 32'd1;
            end
        end
    end

    assign bus.stat_pred_o      = stat_pred;
    assign bus.stat_corr_o      = stat_corr;
    assign bus.stat_recover_o   = stat_recover;
    assign bus.stat_cond_pred_o = stat_cond_pred;
    assign bus.stat_cond_corr_o = stat_cond_corr;
    assign bus.stat_ret_pred_o  = stat_ret_pred;
    assign bus.stat_ret_corr_o  = stat_ret_corr;

endmodule

// File: tb/tb_ctrl_alu.sv
// Directed and randomized bench for ctrl_alu against a behavioural reference model.
module tb_ctrl_alu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_alu_if bus ();

    ctrl_alu dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int passed = 0;
    int total  = 0;

    // Reference statistics: index 0..6 = pred, corr, recover, cond_pred, cond_corr, ret_pred, ret_corr
    int unsigned ref_stat [7];

    // Reference outputs of the current packet
    logic [31:0] m_next, m_res;
    logic        m_dir, m_dv, m_mp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] operand(input logic [6:0] tag, input logic [31:0] rf);
        for (int k = 0; k < 4; k++)
            if (bus.byp_valid_i[k] && bus.byp_tag_i[k] == tag) return bus.byp_data_i[k];
        return rf;
    endfunction

    task automatic model();
        logic [31:0] a, b, seq, pc;
        int sa, sb, off;
        logic defined;
        pc  = bus.pc_i;
        a   = operand(bus.phy_src1_i, bus.src1_data_i);
        b   = operand(bus.phy_src2_i, bus.src2_data_i);
        sa  = $signed(a);
        sb  = $signed(b);
        off = $signed(bus.immed_i[15:0]);
        seq = pc + 32'd8;
        m_next = seq; m_res = 32'd0; m_dir = 1'b0; m_dv = 1'b0; defined = 1'b1;
        case (int'(bus.opcode_i))
            1, 2: begin m_next = {pc[31:28], bus.immed_i, 2'b00}; m_dir = 1'b1; end
            3, 4: begin m_next = a; m_dir = 1'b1; end
            5: m_dir = (sa == sb);
            6: m_dir = (sa != sb);
            7: m_dir = (sa <= 0);
            8: m_dir = (sa > 0);
            9: m_dir = (sa < 0);
            10: m_dir = (sa >= 0);
            default: defined = 1'b0;
        endcase
        if (bus.opcode_i == 8'h02 || bus.opcode_i == 8'h04) begin m_res = seq; m_dv = 1'b1; end
        if (bus.opcode_i >= 8'h05 && bus.opcode_i <= 8'h0A && m_dir) m_next = seq + 32'(off * 8);
        m_mp = bus.valid_i && defined && (m_next != bus.pred_npc_i);
    endtask

    task automatic set_pkt(input logic [7:0] op, input logic [1:0] ct, input logic [31:0] pc,
                           input logic [25:0] imm, input logic [31:0] pred,
                           input logic [31:0] d1, input logic [31:0] d2);
        bus.valid_i     = 1'b1;
        bus.opcode_i    = op;
        bus.ctrl_type_i = ct;
        bus.pc_i        = pc;
        bus.immed_i     = imm;
        bus.pred_npc_i  = pred;
        bus.pred_dir_i  = 1'b0;
        bus.phy_src1_i  = 7'd1;
        bus.phy_src2_i  = 7'd2;
        bus.src1_data_i = d1;
        bus.src2_data_i = d2;
        bus.byp_valid_i = 4'b0000;
    endtask

    // Check combinational outputs mid-cycle, then let the packet cross one rising edge.
    task automatic apply(input string tag);
        #1;
        model();
        check({tag, "_next"}, bus.next_pc_o, m_next);
        check({tag, "_res"}, bus.result_o, m_res);
        check({tag, "_dir"}, 32'(bus.dir_o), 32'(m_dir));
        check({tag, "_dv"}, 32'(bus.dest_valid_o), 32'(m_dv));
        check({tag, "_mp"}, 32'(bus.mispredict_o), 32'(m_mp));
        if (bus.valid_i && rst_n) begin
            ref_stat[0]++;
            if (m_mp) ref_stat[2]++; else ref_stat[1]++;
            if (bus.ctrl_type_i == 2'd1) begin ref_stat[3]++; if (!m_mp) ref_stat[4]++; end
            if (bus.ctrl_type_i == 2'd2) begin ref_stat[5]++; if (!m_mp) ref_stat[6]++; end
        end
        @(negedge clk);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_pred"}, bus.stat_pred_o, ref_stat[0]);
        check({tag, "_corr"}, bus.stat_corr_o, ref_stat[1]);
        check({tag, "_recover"}, bus.stat_recover_o, ref_stat[2]);
        check({tag, "_cond_pred"}, bus.stat_cond_pred_o, ref_stat[3]);
        check({tag, "_cond_corr"}, bus.stat_cond_corr_o, ref_stat[4]);
        check({tag, "_ret_pred"}, bus.stat_ret_pred_o, ref_stat[5]);
        check({tag, "_ret_corr"}, bus.stat_ret_corr_o, ref_stat[6]);
    endtask

    initial begin
        foreach (ref_stat[i]) ref_stat[i] = 0;
        set_pkt(8'h00, 2'd0, 32'd0, 26'd0, 32'd0, 32'd0, 32'd0);
        bus.valid_i = 1'b0;
        bus.byp_tag_i = '0;
        bus.byp_data_i = '0;
        repeat (3) @(negedge clk);
        check_stats("reset");

        // Directed datapath cases, reset still low so no packet is counted
        set_pkt(8'h03, 2'd0, 32'h0, 26'h0, 32'h0, 32'h11, 32'h0);
        bus.phy_src1_i = 7'd5;
        bus.byp_valid_i = 4'b0101;
        bus.byp_tag_i[2] = 7'd5; bus.byp_data_i[2] = 32'h22;
        bus.byp_tag_i[0] = 7'd5; bus.byp_data_i[0] = 32'h33;
        #1 check("fwd_low_port", bus.next_pc_o, 32'h33);
        apply("fwd_hit");
        bus.byp_valid_i = 4'b0000;
        #1 check("fwd_none", bus.next_pc_o, 32'h11);
        apply("fwd_miss");

        set_pkt(8'h05, 2'd1, 32'h1000, 26'h0004, 32'h1008, 32'd7, 32'd7);
        #1 check("beq_next", bus.next_pc_o, 32'h1028);
        check("beq_mp", 32'(bus.mispredict_o), 32'd1);
        apply("beq_a");
        bus.pred_npc_i = 32'h1028;
        #1 check("beq_mp_ok", 32'(bus.mispredict_o), 32'd0);
        apply("beq_b");

        set_pkt(8'h09, 2'd1, 32'h2000, 26'hFFFF, 32'h0, 32'hFFFF_FFFF, 32'd0);
        #1 check("bltz_next", bus.next_pc_o, 32'h2000);
        check("bltz_dir", 32'(bus.dir_o), 32'd1);
        apply("bltz");

        set_pkt(8'h04, 2'd3, 32'h100, 26'h0, 32'h0, 32'h400, 32'd0);
        #1 check("jalr_res", bus.result_o, 32'h108);
        check("jalr_dv", 32'(bus.dest_valid_o), 32'd1);
        apply("jalr");

        set_pkt(8'h7F, 2'd0, 32'h3000, 26'h1234, 32'h0, 32'd1, 32'd2);
        #1 check("undef_next", bus.next_pc_o, 32'h3008);
        apply("undef");

        set_pkt(8'h01, 2'd0, 32'hF000_0010, 26'h3FF_FFFF, 32'h0, 32'd0, 32'd0);
        #1 check("j_next", bus.next_pc_o, 32'hFFFF_FFFC);
        apply("j");
        check_stats("held_in_reset");

        // Release reset, then three conditional packets (two correct) and a mispredicted return
        bus.valid_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        set_pkt(8'h05, 2'd1, 32'h1000, 26'h0004, 32'h1028, 32'd7, 32'd7);
        apply("st_beq");
        set_pkt(8'h06, 2'd1, 32'h1000, 26'h0004, 32'h1008, 32'd7, 32'd7);
        apply("st_bne");
        set_pkt(8'h08, 2'd1, 32'h1000, 26'h0004, 32'h1008, 32'd7, 32'd0);
        apply("st_bgtz");
        set_pkt(8'h03, 2'd2, 32'h1000, 26'h0, 32'h500, 32'd7, 32'd0);
        apply("st_ret");
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("plan_pred", bus.stat_pred_o, 32'd4);
        check("plan_corr", bus.stat_corr_o, 32'd2);
        check("plan_recover", bus.stat_recover_o, 32'd2);
        check("plan_cond_pred", bus.stat_cond_pred_o, 32'd3);
        check("plan_cond_corr", bus.stat_cond_corr_o, 32'd2);
        check("plan_ret_pred", bus.stat_ret_pred_o, 32'd1);
        check("plan_ret_corr", bus.stat_ret_corr_o, 32'd0);

        // Randomized stream against the reference model
        for (int n = 0; n < 300; n++) begin
            logic [7:0] op;
            logic [31:0] pc, d1, d2;
            logic [25:0] imm;
            op  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(11, 255)) : 8'($urandom_range(0, 10));
            pc  = $urandom;
            imm = 26'($urandom);
            d1  = ($urandom_range(0, 3) == 0) ? 32'($signed(4'($urandom))) : $urandom;
            d2  = ($urandom_range(0, 2) == 0) ? d1 : $urandom;
            set_pkt(op, 2'($urandom), pc, imm, 32'd0, d1, d2);
            bus.valid_i    = ($urandom_range(0, 4) != 0);
            bus.pred_dir_i = 1'($urandom);
            bus.phy_src1_i = 7'($urandom_range(0, 7));
            bus.phy_src2_i = 7'($urandom_range(0, 7));
            bus.byp_valid_i = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                bus.byp_tag_i[k]  = 7'($urandom_range(0, 7));
                bus.byp_data_i[k] = ($urandom_range(0, 3) == 0) ? d2 : $urandom;
            end
            case ($urandom_range(0, 2))
                0: bus.pred_npc_i = pc + 32'd8;
                1: bus.pred_npc_i = pc + 32'd8 + 32'($signed(imm[15:0]) * 8);
                default: bus.pred_npc_i = $urandom;
            endcase
            apply("rand");
            if (n % 100 == 99) check_stats("rand_stats");
        end

        // Asynchronous reset mid-stream, well away from any clock edge
        set_pkt(8'h05, 2'd1, 32'h1000, 26'h0004, 32'h0, 32'd7, 32'd7);
        #2 rst_n = 1'b0;
        foreach (ref_stat[i]) ref_stat[i] = 0;
        #1 check_stats("async_clear");
        apply("in_reset");
        check_stats("in_reset_hold");

        // Reset released with a valid packet present: the next edge counts it
        rst_n = 1'b1;
        set_pkt(8'h0A, 2'd2, 32'h40, 26'h0002, 32'h58, 32'd0, 32'd0);
        apply("release");
        check_stats("release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
